// File: rtl/router_req_scheduler.sv
// Request injection stage for one router port: FIFO of host send requests, issued one at a time to the router.
// Optional build macro ROUTER_REQ_RETRY_EN re-issues a timed-out entry up to MAX_RETRY times before dropping it.
module router_req_scheduler #(
    parameter int ADDR_W    = 10,
    parameter int DFX_W     = 2,
    parameter int DEPTH     = 4,
    parameter int START_CYC = 2,
    parameter int TIMEOUT   = 64,
    parameter int MAX_RETRY = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     host_req_valid,
    output logic                     host_req_ready,
    input  logic [ADDR_W-1:0]        host_src_addr,
    input  logic [ADDR_W-1:0]        host_dst_addr,
    input  logic [DFX_W-1:0]         host_src_dfx,
    input  logic [DFX_W-1:0]         host_dst_dfx,
    output logic                     router_start_req,
    output logic [ADDR_W-1:0]        router_scr_addr,
    output logic [ADDR_W-1:0]        router_dst_addr,
    output logic [DFX_W-1:0]         router_src_dfx,
    output logic [DFX_W-1:0]         router_dst_dfx,
    input  logic                     router_send_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     err_timeout
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REQ_W = 2 * ADDR_W + 2 * DFX_W;
    localparam int TMR_W = $clog2(TIMEOUT + START_CYC) + 1;
    localparam int RTY_W = $clog2(MAX_RETRY + 1) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             state_r, state_next_s;
    logic [REQ_W-1:0]   mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]   count_r, count_next_s;
    logic [TMR_W-1:0]   timer_r, timer_next_s;
    logic [RTY_W-1:0]   retry_r, retry_next_s;
    logic [REQ_W-1:0]   req_r, req_next_s;
    logic               ready_r, start_r, err_r, busy_r;
    logic               push_s, pop_s, latch_s, err_next_s;
    logic [REQ_W-1:0]   host_data_s;

    assign push_s      = host_req_valid & ready_r;
    assign host_data_s = {host_src_addr, host_dst_addr, host_src_dfx, host_dst_dfx};

    // Sequencing FSM: issue window, completion wait and timeout policy
    always_comb begin
        state_next_s = state_r;
        timer_next_s = timer_r;
        retry_next_s = retry_r;
        pop_s        = 1'b0;
        latch_s      = 1'b0;
        err_next_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                timer_next_s = {TMR_W{1'b0}};
                if (count_r != {CNT_W{1'b0}}) begin
                    latch_s      = 1'b1;
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (timer_r == TMR_W'(START_CYC - 1)) begin
                    state_next_s = ST_WAIT;
                    timer_next_s = {TMR_W{1'b0}};
                end else begin
                    timer_next_s = timer_r + TMR_W'(1);
                end
            end
            ST_WAIT: begin
                if (router_send_done) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_IDLE;
                    timer_next_s = {TMR_W{1'b0}};
                end else if (timer_r == TMR_W'(TIMEOUT - 1)) begin
                    timer_next_s = {TMR_W{1'b0}};
`ifdef ROUTER_REQ_RETRY_EN
                    if (retry_r < RTY_W'(MAX_RETRY)) begin
                        retry_next_s = retry_r + RTY_W'(1);
                        state_next_s = ST_ISSUE;
                    end else begin
                        pop_s        = 1'b1;
                        err_next_s   = 1'b1;
                        state_next_s = ST_IDLE;
                    end
`else
                    pop_s        = 1'b1;
                    err_next_s   = 1'b1;
                    state_next_s = ST_IDLE;
`endif
                end else begin
                    timer_next_s = timer_r + TMR_W'(1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                timer_next_s = {TMR_W{1'b0}};
            end
        endcase
        if (pop_s) begin
            retry_next_s = {RTY_W{1'b0}};
        end else begin
            retry_next_s = retry_next_s;
        end
    end

    // Occupancy and router field selection (fields clear only once idle with nothing queued)
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
        req_next_s = req_r;
        if (latch_s) begin
            req_next_s = mem_r[rd_ptr_r];
        end else if ((state_next_s == ST_IDLE) && (count_next_s == {CNT_W{1'b0}})) begin
            req_next_s = {REQ_W{1'b0}};
        end else begin
            req_next_s = req_r;
        end
    end

    // FIFO storage array, written on accepted push
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= host_data_s;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            timer_r  <= {TMR_W{1'b0}};
            retry_r  <= {RTY_W{1'b0}};
            req_r    <= {REQ_W{1'b0}};
            ready_r  <= 1'b0;
            start_r  <= 1'b0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            count_r  <= count_next_s;
            timer_r  <= timer_next_s;
            retry_r  <= retry_next_s;
            req_r    <= req_next_s;
            ready_r  <= (count_next_s < CNT_W'(DEPTH));
            start_r  <= (state_next_s == ST_ISSUE);
            err_r    <= err_next_s;
            busy_r   <= (state_next_s != ST_IDLE) | (count_next_s != {CNT_W{1'b0}});
        end
    end

    assign host_req_ready   = ready_r;
    assign router_start_req = start_r;
    assign {router_scr_addr, router_dst_addr, router_src_dfx, router_dst_dfx} = req_r;
    assign busy             = busy_r;
    assign fifo_count       = count_r;
    assign err_timeout      = err_r;

endmodule

// File: tb/tb_router_req_scheduler.sv
// Self-checking bench for router_req_scheduler: scenario tasks plus a queue-based model of the
// request order; build with +define+ROUTER_REQ_RETRY_EN to exercise the retry policy.
module tb_router_req_scheduler;
    localparam int TIMEOUT   = 64;
    localparam int MAX_RETRY = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_req_valid = 1'b0;
    logic        host_req_ready;
    logic [9:0]  host_src_addr = 10'd0, host_dst_addr = 10'd0;
    logic [1:0]  host_src_dfx = 2'd0, host_dst_dfx = 2'd0;
    logic        router_start_req;
    logic [9:0]  router_scr_addr, router_dst_addr;
    logic [1:0]  router_src_dfx, router_dst_dfx;
    logic        router_send_done = 1'b0;
    logic        busy;
    logic [2:0]  fifo_count;
    logic        err_timeout;
    logic [23:0] router_fields;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    logic prev_start = 1'b0;
    logic [23:0] exp_q[$];
    logic [23:0] iss_q[$];

    router_req_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_src_addr(host_src_addr), .host_dst_addr(host_dst_addr),
        .host_src_dfx(host_src_dfx), .host_dst_dfx(host_dst_dfx),
        .router_start_req(router_start_req), .router_scr_addr(router_scr_addr),
        .router_dst_addr(router_dst_addr), .router_src_dfx(router_src_dfx),
        .router_dst_dfx(router_dst_dfx), .router_send_done(router_send_done),
        .busy(busy), .fifo_count(fifo_count), .err_timeout(err_timeout)
    );

    assign router_fields = {router_scr_addr, router_dst_addr, router_src_dfx, router_dst_dfx};

    always #5 clk = ~clk;

    // Observer: records every issue (rising start) with its fields, and counts error pulses
    always @(negedge clk) begin
        if (router_start_req && !prev_start) iss_q.push_back(router_fields);
        if (err_timeout) err_seen = err_seen + 1;
        prev_start = router_start_req;
    end

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [23:0] rand_req();
        return 24'($urandom);
    endfunction

    task automatic drive_req(input logic [23:0] r);
        {host_src_addr, host_dst_addr, host_src_dfx, host_dst_dfx} = r;
    endtask

    task automatic push_req(input logic [23:0] r);
        int n = 0;
        host_req_valid = 1'b1;
        drive_req(r);
        while (!host_req_ready && n < 500) begin step(); n++; end
        checks++;
        if (!host_req_ready) begin
            $display("FAIL push_ready got=%0b exp=1", host_req_ready);
            errors++;
            host_req_valid = 1'b0;
        end else begin
            exp_q.push_back(r);
            step();
            host_req_valid = 1'b0;
        end
    endtask

    task automatic serve_one(input int dly);
        int n = 0;
        logic [23:0] e, got;
        while (iss_q.size() == 0 && n < 500) begin step(); n++; end
        while (router_start_req && n < 500) begin step(); n++; end
        checks++;
        if (iss_q.size() == 0 || exp_q.size() == 0) begin
            $display("FAIL serve_wait got_issues=%0d exp_entries=%0d", iss_q.size(), exp_q.size());
            errors++;
            return;
        end
        got = iss_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin $display("FAIL issue_order got=%h exp=%h", got, e); errors++; end
        repeat (dly) step();
        checks++;
        if (router_fields !== e) begin $display("FAIL field_hold got=%h exp=%h", router_fields, e); errors++; end
        router_send_done = 1'b1;
        step();
        router_send_done = 1'b0;
        checks++;
        if (router_start_req !== 1'b0) begin $display("FAIL idle_gap got=%0b exp=0", router_start_req); errors++; end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (4) step();
        checks++;
        if ({host_req_ready, router_start_req, router_fields, busy, fifo_count, err_timeout} !== 30'd0) begin
            $display("FAIL reset_outputs got=%h exp=0",
                     {host_req_ready, router_start_req, router_fields, busy, fifo_count, err_timeout});
            errors++;
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (host_req_ready !== 1'b1) begin $display("FAIL reset_ready got=%0b exp=1", host_req_ready); errors++; end
        checks++;
        if (fifo_count !== 3'd0 || busy !== 1'b0) begin
            $display("FAIL reset_idle got_count=%0d got_busy=%0b exp=0/0", fifo_count, busy);
            errors++;
        end
    endtask

    task automatic test_basic;
        logic [23:0] r;
        r = {10'h1, 10'h5, 2'b01, 2'b10};
        push_req(r);
        checks++;
        if (router_start_req !== 1'b0) begin $display("FAIL basic_lat_n1 got=%0b exp=0", router_start_req); errors++; end
        step();
        checks++;
        if (router_start_req !== 1'b1 || router_fields !== r) begin
            $display("FAIL basic_issue got_start=%0b got_fields=%h exp=1/%h", router_start_req, router_fields, r);
            errors++;
        end
        step();
        checks++;
        if (router_start_req !== 1'b1) begin $display("FAIL basic_start2 got=%0b exp=1", router_start_req); errors++; end
        step();
        checks++;
        if (router_start_req !== 1'b0 || fifo_count !== 3'd1 || busy !== 1'b1) begin
            $display("FAIL basic_wait got_start=%0b got_count=%0d got_busy=%0b exp=0/1/1",
                     router_start_req, fifo_count, busy);
            errors++;
        end
        repeat (4) step();
        router_send_done = 1'b1;
        step();
        router_send_done = 1'b0;
        checks++;
        if (fifo_count !== 3'd0 || busy !== 1'b0 || router_fields !== 24'd0) begin
            $display("FAIL basic_done got_count=%0d got_busy=%0b got_fields=%h exp=0/0/0",
                     fifo_count, busy, router_fields);
            errors++;
        end
        checks++;
        if (iss_q.size() != 1 || iss_q[0] !== r) begin
            $display("FAIL basic_issue_log got_n=%0d exp_n=1", iss_q.size());
            errors++;
        end
        iss_q.delete();
        exp_q.delete();
    endtask

    task automatic test_fill;
        logic [23:0] r;
        for (int i = 0; i < 4; i++) begin
            r = rand_req();
            host_req_valid = 1'b1;
            drive_req(r);
            checks++;
            if (host_req_ready !== 1'b1) begin $display("FAIL fill_ready%0d got=%0b exp=1", i, host_req_ready); errors++; end
            exp_q.push_back(r);
            step();
        end
        host_req_valid = 1'b0;
        checks++;
        if (host_req_ready !== 1'b0 || fifo_count !== 3'd4) begin
            $display("FAIL fill_full got_ready=%0b got_count=%0d exp=0/4", host_req_ready, fifo_count);
            errors++;
        end
        host_req_valid = 1'b1;
        drive_req(rand_req());
        repeat (3) begin
            step();
            checks++;
            if (fifo_count !== 3'd4) begin $display("FAIL fill_blocked got=%0d exp=4", fifo_count); errors++; end
        end
        host_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) serve_one(int'($urandom_range(0, 8)));
        step();
        checks++;
        if (fifo_count !== 3'd0 || busy !== 1'b0) begin
            $display("FAIL fill_drain got_count=%0d got_busy=%0b exp=0/0", fifo_count, busy);
            errors++;
        end
    endtask

    task automatic test_timeout;
        logic [23:0] r;
        int e0, n;
        r = rand_req();
        e0 = err_seen;
        push_req(r);
`ifdef ROUTER_REQ_RETRY_EN
        n = 0;
        while (err_seen == e0 && n < 1000) begin step(); n++; end
        checks++;
        if (iss_q.size() != MAX_RETRY + 1) begin
            $display("FAIL retry_issues got=%0d exp=%0d", iss_q.size(), MAX_RETRY + 1);
            errors++;
        end
        foreach (iss_q[i]) begin
            checks++;
            if (iss_q[i] !== r) begin $display("FAIL retry_fields got=%h exp=%h", iss_q[i], r); errors++; end
        end
`else
        n = 0;
        while (iss_q.size() == 0 && n < 500) begin step(); n++; end
        while (router_start_req && n < 500) begin step(); n++; end
        n = 0;
        while (err_seen == e0 && n < 1000) begin step(); n++; end
        checks++;
        if (n != TIMEOUT) begin $display("FAIL timeout_delay got=%0d exp=%0d", n, TIMEOUT); errors++; end
        checks++;
        if (iss_q.size() != 1) begin $display("FAIL timeout_issues got=%0d exp=1", iss_q.size()); errors++; end
`endif
        repeat (3) step();
        checks++;
        if (err_seen != e0 + 1) begin $display("FAIL timeout_pulses got=%0d exp=1", err_seen - e0); errors++; end
        checks++;
        if (fifo_count !== 3'd0 || busy !== 1'b0 || router_start_req !== 1'b0) begin
            $display("FAIL timeout_drop got_count=%0d got_busy=%0b got_start=%0b exp=0/0/0",
                     fifo_count, busy, router_start_req);
            errors++;
        end
        iss_q.delete();
        exp_q.delete();
    endtask

    task automatic test_ignore_done;
        int n = 0;
        push_req(rand_req());
        while (!router_start_req && n < 100) begin step(); n++; end
        router_send_done = 1'b1;
        step();
        router_send_done = 1'b0;
        while (router_start_req && n < 100) begin step(); n++; end
        checks++;
        if (fifo_count !== 3'd1 || busy !== 1'b1 || iss_q.size() != 1) begin
            $display("FAIL ignore_done got_count=%0d got_busy=%0b got_issues=%0d exp=1/1/1",
                     fifo_count, busy, iss_q.size());
            errors++;
        end
        serve_one(2);
        checks++;
        if (fifo_count !== 3'd0) begin $display("FAIL ignore_done_pop got=%0d exp=0", fifo_count); errors++; end
    endtask

    task automatic test_async_reset;
        int n = 0;
        push_req(rand_req());
        while (iss_q.size() == 0 && n < 100) begin step(); n++; end
        while (router_start_req && n < 100) begin step(); n++; end
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({host_req_ready, router_start_req, router_fields, busy, fifo_count, err_timeout} !== 30'd0) begin
            $display("FAIL async_reset got=%h exp=0",
                     {host_req_ready, router_start_req, router_fields, busy, fifo_count, err_timeout});
            errors++;
        end
        step();
        rst_n = 1'b1;
        exp_q.delete();
        iss_q.delete();
        step();
        checks++;
        if (host_req_ready !== 1'b1 || fifo_count !== 3'd0) begin
            $display("FAIL async_release got_ready=%0b got_count=%0d exp=1/0", host_req_ready, fifo_count);
            errors++;
        end
        push_req(rand_req());
        serve_one(3);
        checks++;
        if (fifo_count !== 3'd0) begin $display("FAIL async_reinject got=%0d exp=0", fifo_count); errors++; end
    endtask

    task automatic test_random;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    repeat ($urandom_range(0, 3)) step();
                    push_req(rand_req());
                end
            end
            begin
                for (int j = 0; j < 16; j++) serve_one(int'($urandom_range(0, 8)));
            end
        join
        step();
        checks++;
        if (fifo_count !== 3'd0 || busy !== 1'b0 || exp_q.size() != 0) begin
            $display("FAIL random_drain got_count=%0d got_busy=%0b left=%0d exp=0/0/0",
                     fifo_count, busy, exp_q.size());
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_timeout();
        test_ignore_done();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
